uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
// - UART transmit PHY: the responder on the byte-level tx handshake (tx_start/tx_byte/tx_done) driven by the UART-BRAM controller.
// - Serializes one 8-bit byte per request onto o_txd as a standard async frame: start, 8 data LSB-first, optional parity, 1-2 stop.
// - Sits between the controller and the board TX pin; one instance per UART link.
// PARAMETERS
// - CLKS_PER_BIT  868  i_clk cycles per bit (100 MHz / 115200); legal >= 2
// - PARITY_EN     0    1 = append parity bit after D7
// - PARITY_ODD    0    parity type when PARITY_EN=1: 0 even, 1 odd
// - STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
// - i_clk          in   1  system clock
// - i_rst          in   1  reset; synchronous, active-high
// - i_tx_start     in   1  1-cycle request; sampled only in IDLE
// - i_tx_byte      in   8  byte to send; sampled in the same cycle as i_tx_start
// - o_tx_done      out  1  1-cycle pulse: frame fully on the line
// - o_tx_busy      out  1  high from the accept edge until o_tx_done
// - o_txd          out  1  serial line, idle high
// - o_debug_state  out  3  current FSM state encoding
// BEHAVIOUR
// - Reset (sync): state=IDLE, o_txd=1, o_tx_busy=0, o_tx_done=0, bit counter=0, baud counter=0, shift reg=0.
// - Reset mid-frame: next edge forces o_txd=1, IDLE, and no done pulse. The partial frame is dropped.
// - States: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
// - IDLE: o_txd=1. If i_tx_start=1 at edge N:
//   - latch i_tx_byte into the shift reg;
//   - compute the parity bit (^byte, XOR PARITY_ODD);
//   - from N+1: state=START, o_txd=0, o_tx_busy=1.
// - Each bit is held exactly CLKS_PER_BIT cycles.
//   - Baud counter runs 0..CLKS_PER_BIT-1 and clears on every state or bit change.
// - START -> DATA. DATA sends shreg[0], then shifts right.
//   - After 8 bits: go to PARITY if PARITY_EN, else STOP.
// - PARITY -> STOP. STOP holds o_txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
// - STOP -> IDLE. In the first IDLE cycle: o_tx_done=1 and o_tx_busy=0. o_txd stays 1.
// - Timing: with FRAME = 1+8+PARITY_EN+STOP_BITS, o_tx_done is high at cycle N+1+FRAME*CLKS_PER_BIT, for exactly one cycle.
// - A start arriving in the same cycle as o_tx_done is accepted (state is IDLE). No idle gap is forced.
//   - Back-to-back frames: the next start bit immediately follows the previous stop bit(s).
// - i_tx_start while busy is ignored: no queueing, no error flag. i_tx_byte changes while busy have no effect.
// - o_tx_done is never high while o_tx_busy=1. It stays 0 forever if no start is ever accepted.
// - All outputs registered. No combinational path from inputs to outputs.
// - Widths:
//   - baud counter $clog2(CLKS_PER_BIT);
//   - bit counter 3 bits, wraps 7->0 only on leaving DATA;
//   - stop counter 1 bit.
// STRUCTURE
// - Shared package uart_pkg:
//   - typedef enum logic [2:0] tx_state_t (IDLE..STOP);
//   - localparam UART_DEF_CLKS_PER_BIT=868;
//   - localparam UART_DATA_BITS=8.
// - Sub-module uart_baud_counter (CLKS_PER_BIT):
//   - inputs i_clk, i_rst, i_clr;
//   - output o_bit_end, high on the last cycle of each bit period;
//   - shared later with the RX side.
// - Elaboration check: fatal if CLKS_PER_BIT<2 or STOP_BITS not in {1,2}.
// TESTING (CLKS_PER_BIT=4 unless noted; edge N = accept)
// - Reset with no stimulus for 100 cycles -> o_txd=1, busy=0, done never asserts.
// - Start byte 0xA5, 8N1 -> o_txd per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; busy N+1..N+40; done=1 only at N+41.
// - Two bytes 0x00 then 0xFF, 2nd start in done cycle -> 2nd start bit begins at N+42, no extra idle.
// - Start pulses at N+5 and N+20 during a frame -> ignored; exactly one done; line carries the 1st byte only.
// - PARITY_EN=1, STOP_BITS=2, byte 0x07 -> even parity bit 1 (odd: 0); done at N+1+12*4=N+49.
// - Reset asserted at N+15 mid-DATA -> N+16: o_txd=1, busy=0; no done pulse; next start sends a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding and link-wide constants.
package uart_pkg;

   localparam int unsigned UART_DEF_CLKS_PER_BIT = 868;
   localparam int unsigned UART_DATA_BITS        = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_serializer_if.sv
// Byte-level tx handshake between the UART-BRAM controller (master) and the
// serializer (slave), plus the serial line and debug state.
interface uart_tx_serializer_if;
   import uart_pkg::*;

   logic                      i_tx_start;
   logic [UART_DATA_BITS-1:0] i_tx_byte;
   logic                      o_tx_done;
   logic                      o_tx_busy;
   logic                      o_txd;
   logic [2:0]                o_debug_state;

   modport master (
      output i_tx_start, i_tx_byte,
      input  o_tx_done, o_tx_busy, o_txd, o_debug_state
   );

   modport slave (
      input  i_tx_start, i_tx_byte,
      output o_tx_done, o_tx_busy, o_txd, o_debug_state
   );

endinterface : uart_tx_serializer_if

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit period. Written to be reused by the RX side.
module uart_baud_counter #(
   parameter int unsigned CLKS_PER_BIT = uart_pkg::UART_DEF_CLKS_PER_BIT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_bit_end
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (i_clr || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_bit_end = (cnt_q == CNT_LAST);

endmodule : uart_baud_counter

// File: rtl/uart_tx_serializer.sv
// UART transmit PHY: accepts one byte per tx_start and shifts it out as
// start / 8 data LSB-first / optional parity / 1-2 stop bits on o_txd.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input logic                 i_clk,
   input logic                 i_rst,
   uart_tx_serializer_if.slave bus
);

   localparam int unsigned BIT_CNT_W = $clog2(UART_DATA_BITS);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(UART_DATA_BITS - 1);
   localparam logic STOP_LAST   = 1'(STOP_BITS - 1);
   localparam logic PAR_ODD_BIT = 1'(PARITY_ODD);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $fatal(1, "uart_tx_serializer: CLKS_PER_BIT must be >= 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $fatal(1, "uart_tx_serializer: STOP_BITS must be 1 or 2");
   end

   tx_state_t                 state_q,   state_d;
   logic [UART_DATA_BITS-1:0] shreg_q,   shreg_d;
   logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                      stop_cnt_q, stop_cnt_d;
   logic                      par_q,     par_d;
   logic                      txd_q,     txd_d;
   logic                      busy_q,    busy_d;
   logic                      done_q,    done_d;
   logic                      bit_end;
   logic                      baud_clr;

   // Held in IDLE so the first bit period starts at zero on the accept edge;
   // elsewhere the counter wraps exactly on every bit/state change.
   assign baud_clr = (state_q == IDLE);

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (baud_clr),
      .o_bit_end (bit_end)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      par_d      = par_q;
      txd_d      = txd_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            txd_d  = 1'b1;
            busy_d = 1'b0;
            if (bus.i_tx_start) begin
               shreg_d = bus.i_tx_byte;
               par_d   = (^bus.i_tx_byte) ^ PAR_ODD_BIT;
               state_d = START;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               txd_d   = shreg_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d = PARITY;
                     txd_d   = par_q;
                  end else begin
                     state_d = STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  txd_d     = shreg_q[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               txd_d   = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_cnt_q == STOP_LAST) begin
                  stop_cnt_d = 1'b0;
                  state_d    = IDLE;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         par_q      <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         par_q      <= par_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.o_txd         = txd_q;
   assign bus.o_tx_busy     = busy_q;
   assign bus.o_tx_done     = done_q;
   assign bus.o_debug_state = state_q;

endmodule : uart_tx_serializer

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: three configurations (8N1, 8E2, 8O2)
// checked cycle by cycle against a queue of expected {state, txd, busy, done}.
module tb_uart_tx_serializer;
   import uart_pkg::*;

   localparam int unsigned CPB = 4;
   localparam logic [5:0]  IDLE_V = 6'b000_1_0_0;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   cyc;

   logic [5:0] qa[$];
   logic [5:0] qb[$];
   logic [5:0] qc[$];

   uart_tx_serializer_if ifa ();
   uart_tx_serializer_if ifb ();
   uart_tx_serializer_if ifc ();

   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
      dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
      dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
      dut_c (.i_clk(clk), .i_rst(rst), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {state, txd, busy, done} for sample j (1 = first cycle after accept).
   function automatic logic [5:0] exp_at(logic [7:0] b, int par_en, int odd, int stops, int j);
      int nbits;
      int bi;
      logic p;
      nbits = 1 + 8 + par_en + stops;
      p = (^b) ^ odd[0];
      if (j > nbits * int'(CPB)) return {3'd0, 1'b1, 1'b0, 1'b1};
      bi = (j - 1) / int'(CPB);
      if (bi == 0)                    return {3'd1, 1'b0, 1'b1, 1'b0};
      if (bi <= 8)                    return {3'd2, b[bi-1], 1'b1, 1'b0};
      if ((par_en != 0) && (bi == 9)) return {3'd3, p, 1'b1, 1'b0};
      return {3'd4, 1'b1, 1'b1, 1'b0};
   endfunction

   task automatic start(int which, logic [7:0] b);
      case (which)
         0: begin
            ifa.i_tx_start = 1'b1; ifa.i_tx_byte = b;
            for (int j = 1; j <= 10 * int'(CPB) + 1; j++) qa.push_back(exp_at(b, 0, 0, 1, j));
         end
         1: begin
            ifb.i_tx_start = 1'b1; ifb.i_tx_byte = b;
            for (int j = 1; j <= 12 * int'(CPB) + 1; j++) qb.push_back(exp_at(b, 1, 0, 2, j));
         end
         default: begin
            ifc.i_tx_start = 1'b1; ifc.i_tx_byte = b;
            for (int j = 1; j <= 12 * int'(CPB) + 1; j++) qc.push_back(exp_at(b, 1, 1, 2, j));
         end
      endcase
   endtask

   task automatic chk(string tag, logic [5:0] obs, logic [5:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed{st,txd,busy,done}=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   // One clock: drop request pulses, then compare every DUT against its queue.
   task automatic step();
      logic [5:0] e;
      @(negedge clk);
      cyc++;
      ifa.i_tx_start = 1'b0;
      ifb.i_tx_start = 1'b0;
      ifc.i_tx_start = 1'b0;
      e = (qa.size() != 0) ? qa.pop_front() : IDLE_V;
      chk("dut_a_8N1", {ifa.o_debug_state, ifa.o_txd, ifa.o_tx_busy, ifa.o_tx_done}, e);
      e = (qb.size() != 0) ? qb.pop_front() : IDLE_V;
      chk("dut_b_8E2", {ifb.o_debug_state, ifb.o_txd, ifb.o_tx_busy, ifb.o_tx_done}, e);
      e = (qc.size() != 0) ? qc.pop_front() : IDLE_V;
      chk("dut_c_8O2", {ifc.o_debug_state, ifc.o_txd, ifc.o_tx_busy, ifc.o_tx_done}, e);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      cyc = 0;
      rst = 1'b1;
      ifa.i_tx_start = 1'b0; ifa.i_tx_byte = 8'h00;
      ifb.i_tx_start = 1'b0; ifb.i_tx_byte = 8'h00;
      ifc.i_tx_start = 1'b0; ifc.i_tx_byte = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Quiet line after reset: idle high, never busy, never done.
      repeat (100) step();

      // 0xA5 8N1: line 0,1,0,1,0,0,1,0,1,1; done one cycle after the stop bit.
      start(0, 8'hA5);
      repeat (10 * CPB + 1) step();
      repeat (3) step();

      // 0x00 then 0xFF with the second start in the done cycle: no idle gap.
      start(0, 8'h00);
      repeat (10 * CPB + 1) step();
      start(0, 8'hFF);
      repeat (10 * CPB + 1) step();
      repeat (3) step();

      // Requests and byte changes while busy are ignored.
      start(0, 8'h3C);
      for (int j = 1; j <= 10 * int'(CPB) + 1; j++) begin
         step();
         if (j == 5 || j == 20) begin
            ifa.i_tx_start = 1'b1;
            ifa.i_tx_byte  = 8'hC3;
         end
         if (j == 10) ifa.i_tx_byte = 8'h99;
      end
      repeat (45) step();

      // Parity + two stop bits, even and odd, two bytes each.
      start(1, 8'h07);
      start(2, 8'h07);
      repeat (12 * CPB + 1) step();
      start(1, 8'h5A);
      start(2, 8'h5A);
      repeat (12 * CPB + 1) step();
      repeat (3) step();

      // Reset mid-DATA drops the frame; the following frame is clean.
      start(0, 8'h96);
      repeat (14) step();
      rst = 1'b1;
      qa.delete();
      step();
      rst = 1'b0;
      repeat (5) step();
      start(0, 8'h81);
      repeat (10 * CPB + 1) step();
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_uart_tx_serializer
